fifo_pkt_reader: RTL and testbench

FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

---
 rtl/fifo_pkt_reader.sv | 112 +++++++++++
 tb/tb_fifo_pkt_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// Packet reader for a first-word-fall-through FIFO: strips the length header and
// forwards the payload words through a 2-entry output buffer with valid/ready.
module fifo_pkt_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  ren,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  zero_len,
  output logic [31:0]           pkt_cnt
);

  typedef enum logic {S_HDR, S_PAY} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t                state;
  logic [LEN_WIDTH-1:0]  rem;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic                  buf_last [2];
  logic [1:0]            occ;
  logic                  hdr_pop;
  logic                  push;
  logic                  pop;

  assign hdr_len = rdata[LEN_WIDTH-1:0];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    ren = 1'b0;
    if (!rst) begin
      if (state == S_HDR) ren = !empty;
      else                ren = !empty && (occ != 2'd2);
    end
  end

  assign hdr_pop = ren && (state == S_HDR);
  assign push    = ren && (state == S_PAY);
  assign pop     = (occ != 2'd0) && m_ready;

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_data[0];
  assign m_last  = buf_last[0];
  assign busy    = (state == S_PAY);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_HDR;
      rem      <= '0;
      occ      <= 2'd0;
      zero_len <= 1'b0;
      pkt_cnt  <= 32'd0;
      // NOTE: the two buffer entries are plain registers, cleared so m_data/m_last read 0 out of reset.
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
    end else begin
      zero_len <= 1'b0;

      case (state)
        S_HDR: begin
          if (hdr_pop) begin
            rem <= hdr_len;
            if (hdr_len == '0) zero_len <= 1'b1;
            else               state    <= S_PAY;
          end
        end
        S_PAY: begin
          if (push) begin
            rem <= rem - LEN_ONE;
            if (rem == LEN_ONE) state <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase

      if (pop && buf_last[0]) pkt_cnt <= pkt_cnt + 32'd1;

      // Entry 0 is always the head; push is blocked at occ==2, so push+pop implies occ==1.
      case ({push, pop})
        2'b10: begin
          buf_data[occ[0]] <= rdata;
          buf_last[occ[0]] <= (rem == LEN_ONE);
          occ              <= occ + 2'd1;
        end
        2'b01: begin
          buf_data[0] <= buf_data[1];
          buf_last[0] <= buf_last[1];
          occ         <= occ - 2'd1;
        end
        2'b11: begin
          buf_data[0] <= rdata;
          buf_last[0] <= (rem == LEN_ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: a queue models the upstream FWFT FIFO, and a
// scoreboard monitor checks every transferred word against the expected stream.
module tb_fifo_pkt_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        empty;
  logic [31:0] rdata;
  logic        ren;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        zero_len;
  logic [31:0] pkt_cnt;

  word_t       exp_q[$];
  logic [31:0] fifo_q[$];
  int          xfer_cyc[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          pops     = 0;
  int          zl_cnt   = 0;
  bit          stall    = 1'b0;
  word_t       mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fifo_pkt_reader #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .empty    (empty),
    .rdata    (rdata),
    .ren      (ren),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .zero_len (zero_len),
    .pkt_cnt  (pkt_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-low-phase, when inputs for the coming edge are settled.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (empty === 1'b1) check("ren_while_empty", ren, 0);
      if (zero_len === 1'b1) zl_cnt++;
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: actual=%0h required=none", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_data", m_data, mon_e.data);
          check("sb_last", m_last, mon_e.last);
          xfer_cyc.push_back(cyc);
        end
      end
    end
  end

  // One clock of the upstream FIFO model: present head, pop on ren.
  task automatic cycle();
    bit          popped;
    logic [31:0] tmp;
    empty = stall || (fifo_q.size() == 0);
    rdata = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    #1;
    popped = ren;
    @(posedge clk);
    if (popped && fifo_q.size() != 0) begin
      tmp = fifo_q.pop_front();
      pops++;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; empty = 1'b0; rdata = 32'h5; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ren", ren, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_zero_len", zero_len, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    rst = 1'b0; empty = 1'b1;
    cycle();

    // Header 3 then three words, streaming back to back.
    fifo_q = '{32'h3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    exp_q.push_back({32'h1111_1111, 1'b0});
    exp_q.push_back({32'h2222_2222, 1'b0});
    exp_q.push_back({32'h3333_3333, 1'b1});
    xfer_cyc.delete();
    c0 = cyc;
    drain("t1_drain", 50);
    check("t1_xfers", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      check("t1_latency", xfer_cyc[0] - c0, 2);
      check("t1_back2back_1", xfer_cyc[1] - xfer_cyc[0], 1);
      check("t1_back2back_2", xfer_cyc[2] - xfer_cyc[1], 1);
    end
    check("t1_pkt_cnt", pkt_cnt, 1);
    check("t1_busy_idle", busy, 0);

    // Zero-length header (upper bits set) then a 1-word packet.
    zl_cnt = 0;
    fifo_q = '{32'hDEAD_0000, 32'h0000_0001, 32'hA5A5_A5A5};
    exp_q.push_back({32'hA5A5_A5A5, 1'b1});
    drain("t2_drain", 50);
    check("t2_zero_len_pulses", zl_cnt, 1);
    check("t2_pkt_cnt", pkt_cnt, 2);

    // Backpressure: only two payload words may be popped into the buffer.
    m_ready = 1'b0;
    pops = 0;
    fifo_q = '{32'h4, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    exp_q.push_back({32'hB000_0000, 1'b0});
    exp_q.push_back({32'hB000_0001, 1'b0});
    exp_q.push_back({32'hB000_0002, 1'b0});
    exp_q.push_back({32'hB000_0003, 1'b1});
    repeat (8) cycle();
    check("t3_pops", pops, 3);
    check("t3_ren_stalled", ren, 0);
    check("t3_m_valid", m_valid, 1);
    check("t3_m_data_hold", m_data, 32'hB000_0000);
    cycle();
    check("t3_m_data_stable", m_data, 32'hB000_0000);
    m_ready = 1'b1;
    drain("t3_drain", 50);
    check("t3_pkt_cnt", pkt_cnt, 3);

    // Randomly starved FIFO and throttled sink.
    fifo_q = '{32'h6, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    for (int i = 0; i < 6; i++) exp_q.push_back({32'hC0 + 32'(i), (i == 5)});
    for (int n = 0; n < 300 && (exp_q.size() != 0 || fifo_q.size() != 0); n++) begin
      stall   = ($urandom_range(0, 1) == 1);
      m_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    stall = 1'b0; m_ready = 1'b1;
    drain("t4_drain", 50);
    check("t4_pkt_cnt", pkt_cnt, 4);

    // Maximum length header: payload never marked last.
    fifo_q = '{32'h0000_FFFF, 32'hD0, 32'hD1, 32'hD2};
    exp_q.push_back({32'hD0, 1'b0});
    exp_q.push_back({32'hD1, 1'b0});
    exp_q.push_back({32'hD2, 1'b0});
    drain("t5_drain", 50);
    check("t5_busy", busy, 1);
    check("t5_pkt_cnt", pkt_cnt, 4);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5_busy_after_rst", busy, 0);

    // Reset after 2 of 5 payload words; the leftover FIFO words are re-parsed.
    m_ready = 1'b0;
    pops = 0;
    fifo_q = '{32'h5, 32'hE0, 32'hE1, 32'hAAAA_0001, 32'h5555_5555, 32'h0000_0000};
    for (int n = 0; n < 20 && pops < 3; n++) cycle();
    check("t6_pops_before_rst", pops, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_m_valid", m_valid, 0);
    check("t6_pkt_cnt", pkt_cnt, 0);
    check("t6_busy", busy, 0);
    zl_cnt = 0;
    m_ready = 1'b1;
    exp_q.push_back({32'h5555_5555, 1'b1});
    drain("t6_drain", 50);
    check("t6_pkt_cnt_after", pkt_cnt, 1);
    check("t6_zero_len_pulses", zl_cnt, 1);

    // Counter wrap from all-ones.
    force dut.pkt_cnt = 32'hFFFF_FFFF;
    cycle();
    release dut.pkt_cnt;
    cycle();
    check("t7_preload", pkt_cnt, 32'hFFFF_FFFF);
    fifo_q = '{32'h1, 32'h00C0_FFEE};
    exp_q.push_back({32'h00C0_FFEE, 1'b1});
    drain("t7_drain", 50);
    check("t7_pkt_cnt_wrap", pkt_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
